// File: rtl/snake_pkg.sv
// snake_pkg: shared cell codes, colours, board defaults and a constant shift-add multiply helper.
package snake_pkg;
  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;
  localparam int CELL_SHIFT_DEF = 4;
  typedef enum logic [1:0] {CELL_EMPTY, CELL_BODY, CELL_HEAD, CELL_FOOD} cell_t;
  localparam logic [11:0] COLOR_EMPTY  = 12'h000;
  localparam logic [11:0] COLOR_BODY   = 12'h0F0;
  localparam logic [11:0] COLOR_HEAD   = 12'h0A0;
  localparam logic [11:0] COLOR_FOOD   = 12'hF00;
  localparam logic [11:0] COLOR_BORDER = 12'h444;
  localparam logic [11:0] COLOR_GRID   = 12'h222;
  function automatic logic [11:0] cell_color(logic [1:0] c);
    return cell_t'(c) == CELL_BODY ? COLOR_BODY :
           cell_t'(c) == CELL_HEAD ? COLOR_HEAD :
           cell_t'(c) == CELL_FOOD ? COLOR_FOOD : COLOR_EMPTY;
  endfunction
  // k is a constant, so this folds into a fixed set of shifted adds
  function automatic logic [10:0] mul_const(logic [10:0] a, int k);
    logic [10:0] s;
    s = '0;
    for (int i = 0; i < 11; i++)
      if (k[i]) s = s + (a << i);
    return s;
  endfunction
endpackage

// File: rtl/snake_board_ram.sv
// snake_board_ram: 2048x2 simple dual-port board memory, synchronous read (old data on collision).
module snake_board_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [10:0] waddr,
  input  logic [1:0]  wdata,
  input  logic [10:0] raddr,
  output logic [1:0]  rdata
);
  logic [1:0] mem [2048];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/snake_pixel_gen.sv
// snake_pixel_gen: 2-stage board-to-RGB renderer for a VGA timing generator.
// Optional SNAKE_GRID_LINES_EN draws 0x222 grid lines on empty cells.
module snake_pixel_gen import snake_pkg::*; #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CELL_SHIFT = CELL_SHIFT_DEF,
  parameter int GRID_W     = GRID_W_DEF,
  parameter int GRID_H     = GRID_H_DEF
) (
  input  logic        VGA_clock,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        blank,
  input  logic        HS_in,
  input  logic        VS_in,
  input  logic        wr_en,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_data,
  output logic [3:0]  R,
  output logic [3:0]  G,
  output logic [3:0]  B,
  output logic        HS,
  output logic        VS,
  output logic        frame_tick
);
  logic [10:0] rd_addr;
  logic [1:0]  rd_data;
  logic        valid_q, blank_q, border_q, hs_q, vs_q, line_q, line_d;
  logic [11:0] rgb_q, color;
  assign rd_addr = mul_const(vcount >> CELL_SHIFT, GRID_W) + (hcount >> CELL_SHIFT);
  snake_board_ram u_ram (
    .clk(VGA_clock),
    .we(wr_en && !reset && wr_addr < 11'(GRID_W * GRID_H)),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
`ifdef SNAKE_GRID_LINES_EN
  assign line_d = hcount[CELL_SHIFT-1:0] == '0 || vcount[CELL_SHIFT-1:0] == '0;
`else
  assign line_d = 1'b0;
`endif
  // valid_q hides the unreset RAM output on the first cycle after reset
  always_comb
    color = !valid_q || blank_q ? COLOR_EMPTY :
            border_q ? COLOR_BORDER :
            line_q && rd_data == CELL_EMPTY ? COLOR_GRID : cell_color(rd_data);
  always_ff @(posedge VGA_clock or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      blank_q  <= 1'b0;
      border_q <= 1'b0;
      line_q   <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      rgb_q    <= '0;
      HS       <= 1'b1;
      VS       <= 1'b1;
    end else begin
      valid_q  <= 1'b1;
      blank_q  <= blank;
      border_q <= hcount >= 11'(GRID_W << CELL_SHIFT) || hcount >= 11'(H_ACTIVE) ||
                  vcount >= 11'(GRID_H << CELL_SHIFT);
      line_q   <= line_d;
      hs_q     <= HS_in;
      vs_q     <= VS_in;
      rgb_q    <= color;
      HS       <= hs_q;
      VS       <= vs_q;
    end
  end
  assign {R, G, B} = rgb_q;
  assign frame_tick = !reset && vcount == 11'(V_ACTIVE) && hcount == '0;
endmodule

// File: doc/snake_pixel_gen.md
SNAKE_PIXEL_GEN -- requirements
Module: snake_pixel_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter CELL_SHIFT, default 4, log2 of the square cell size in pixels (16x16).
REQ-004 SHALL have parameter GRID_W, default 40, board width in cells.
REQ-005 SHALL have parameter GRID_H, default 30, board height in cells.
REQ-006 SHALL use one clock and an asynchronous, active-high reset: VGA_clock and reset.
REQ-007 SHALL have port VGA_clock  in  1  pixel clock, shared with the VGA timing generator.
REQ-008 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-009 SHALL have ports hcount, vcount  in  11 each  pixel and line counters from the timing generator.
REQ-010 SHALL have ports blank, HS_in, VS_in  in  1 each  timing-generator blank and syncs.
REQ-011 SHALL have port wr_en  in  1  board write strobe from game logic.
REQ-012 SHALL have port wr_addr  in  11  cell index, row*GRID_W+col.
REQ-013 SHALL have port wr_data  in  2  cell code: 0 empty, 1 body, 2 head, 3 food.
REQ-014 SHALL have ports R, G, B  out  4 each  pixel colour.
REQ-015 SHALL have ports HS, VS  out  1 each  syncs delay-matched to RGB.
REQ-016 SHALL have port frame_tick  out  1  one-cycle pulse at start of vertical blank.

Function
REQ-017 SHALL register cell address and pixel flags in stage 1, read the board RAM synchronously, and register colour in stage 2, so that RGB/HS/VS lag hcount/vcount/blank/HS_in/VS_in by exactly 2 cycles.
REQ-018 SHALL compute address = (vcount>>CELL_SHIFT)*GRID_W + (hcount>>CELL_SHIFT), using shift-add only and no multiplier, at 11-bit width.
REQ-019 SHALL drive RGB = 0 whenever delayed blank = 1.
REQ-020 SHALL drive the border colour 0x444 for pixels that are not blanked and have hcount >= GRID_W<<CELL_SHIFT or vcount >= GRID_H<<CELL_SHIFT; RAM data is ignored for these pixels.
REQ-021 SHALL map cell codes to colours: empty 0x000, body 0x0F0, head 0x0A0, food 0xF00 (RGB nibbles).
REQ-022 SHALL perform a write when wr_en = 1 and wr_addr < GRID_W*GRID_H, and SHALL ignore writes with wr_addr >= GRID_W*GRID_H.
REQ-023 SHALL return old data on a same-cycle read/write to one address; the new value SHALL be visible from the next read.
REQ-024 SHALL pulse frame_tick for exactly one cycle when vcount == V_ACTIVE and hcount == 0, aligned with the input counters (no pipeline delay).
REQ-025 SHALL NOT clear board RAM contents on reset.

Reset
REQ-026 SHALL force R, G, B, frame_tick and all pipeline registers to 0 asynchronously on reset.
REQ-027 SHALL force HS and VS to 1 (inactive) on reset.
REQ-028 SHALL resume output after reset deassertion with the first valid pixel 2 cycles after the first sampled counter.
REQ-029 SHALL leave RAM writes unaffected by reset except during the cycle it is asserted, when writes SHALL be suppressed.

Configuration
REQ-030 SHALL draw grid lines when SNAKE_GRID_LINES_EN is defined: an empty cell pixel with hcount[CELL_SHIFT-1:0] == 0 or vcount[CELL_SHIFT-1:0] == 0 SHALL be 0x222; non-empty cells are unaffected.
REQ-031 SHALL render empty cells uniformly 0x000 when SNAKE_GRID_LINES_EN is undefined, and the boundary-flag logic SHALL be absent.

Structure
REQ-032 SHALL place cell-code constants, colour constants and the GRID_W/GRID_H/CELL_SHIFT defaults in the shared package snake_pkg.
REQ-033 SHALL implement the board memory as sub-module snake_board_ram: simple dual-port, 2048x2 depth, one synchronous read port and one synchronous write port.

Verification
REQ-034 SHALL verify pipeline latency: write head at addr 0; pixel (0,0) unblanked -> RGB 0x0A0 exactly 2 cycles later, with HS/VS matching inputs delayed 2.
REQ-035 SHALL verify blanking: blank = 1 over a food cell -> RGB 0x000.
REQ-036 SHALL verify border: hcount 650, vcount 10, blank 0 -> RGB 0x444; and wr_addr 1200 with wr_en -> no cell changes.
REQ-037 SHALL verify read/write collision: cell 41 empty, write food to 41 while pixel (16,16) is read -> old colour, then 0xF00 on the next read of that cell.
REQ-038 SHALL verify frame_tick: a full 800x525 frame -> exactly one pulse, at vcount 480, hcount 0.
REQ-039 SHALL verify reset mid-line: reset asserted at hcount 300 -> RGB 0, HS = VS = 1 immediately; RAM contents are preserved after release.
